// File: rtl/maj_bist_pkg.sv
// Shared types and constants for the majority-gate BIST controller.
package maj_bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } bist_state_t;

  localparam int unsigned     ERR_W   = 32;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

endpackage

// File: rtl/maj_popcount_ref.sv
// Combinational majority reference: ref_y = (popcount(vec_i) >= THRESH).
module maj_popcount_ref #(
  parameter int unsigned N      = 27,
  parameter int unsigned THRESH = N / 2 + 1
) (
  input  logic [N-1:0] vec_i,
  output logic         ref_y
);

  localparam int unsigned PCW = $clog2(N + 1);

  logic [PCW-1:0] cnt;

  always_comb begin
    cnt = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cnt = cnt + PCW'(vec_i[i]);
    end
    ref_y = (32'(cnt) >= THRESH);
  end

endmodule

// File: rtl/maj_bist_ctrl.sv
// Exhaustive-sweep BIST controller for a majority DUT with latency-matched compare.
// Optional first-failure capture is enabled by defining MAJ_BIST_FAILCAP_EN.
module maj_bist_ctrl
  import maj_bist_pkg::*;
#(
  parameter int unsigned N      = 27,
  parameter int unsigned THRESH = N / 2 + 1,
  parameter int unsigned LAT    = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [N-1:0]     x_out,
  input  logic             y_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [N-1:0]     fail_vec,
  output logic             fail_valid
);

  bist_state_t      state_q, state_d;
  logic [N-1:0]     x_q, x_d;
  logic [2:0]       drain_q, drain_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  logic             launch;
  logic             last_vec;
  logic             run;
  logic             cmp_valid;
  logic [N-1:0]     cmp_vec;
  logic             ref_y;
  logic             mismatch;

  assign run      = (state_q == RUN);
  assign launch   = start && ((state_q == IDLE) || (state_q == DONE));
  assign last_vec = (x_q == '1);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = RUN;
      RUN:        if (last_vec) state_d = (LAT == 0) ? DONE : DRAIN;
      DRAIN:      if (drain_q == 3'(LAT - 1)) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == RUN) || (state_q == DRAIN);
    done      = done_q;
    pass      = pass_q;
    x_out     = x_q;
    err_count = err_q;
  end

  // Delay (valid, vector) by LAT cycles so each y_in is judged against the vector that produced it.
  if (LAT == 0) begin : g_nolat
    assign cmp_valid = run;
    assign cmp_vec   = x_q;
  end else begin : g_lat
    logic [LAT-1:0] v_q;
    logic [N-1:0]   vec_q [LAT];

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= '0;
      end else begin
        v_q[0] <= run;
        for (int unsigned i = 1; i < LAT; i++) v_q[i] <= v_q[i-1];
      end
    end

    always_ff @(posedge clk) begin
      vec_q[0] <= x_q;
      for (int unsigned i = 1; i < LAT; i++) vec_q[i] <= vec_q[i-1];
    end

    assign cmp_valid = v_q[LAT-1];
    assign cmp_vec   = vec_q[LAT-1];
  end

  maj_popcount_ref #(
    .N      (N),
    .THRESH (THRESH)
  ) u_ref (
    .vec_i (cmp_vec),
    .ref_y (ref_y)
  );

  assign mismatch = cmp_valid && (y_in != ref_y);

  always_comb begin
    x_d     = x_q;
    err_d   = err_q;
    drain_d = (state_q == DRAIN) ? drain_q + 3'd1 : '0;
    if (launch) begin
      x_d   = '0;
      err_d = '0;
    end else begin
      if (run && !last_vec) x_d = x_q + N'(1);
      if (mismatch && (err_q != ERR_MAX)) err_d = err_q + ERR_W'(1);
    end
    done_d = (state_d == DONE) && (state_q != DONE);
    // pass samples err_d so it already includes the final compare landing with done.
    if (launch)      pass_d = 1'b0;
    else if (done_d) pass_d = (err_d == '0);
    else             pass_d = pass_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q     <= '0;
      drain_q <= '0;
      err_q   <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      x_q     <= x_d;
      drain_q <= drain_d;
      err_q   <= err_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

`ifdef MAJ_BIST_FAILCAP_EN
  logic [N-1:0] fvec_q;
  logic         fval_q;

  always_ff @(posedge clk) begin
    if (rst || launch) begin
      fvec_q <= '0;
      fval_q <= 1'b0;
    end else if (mismatch && !fval_q) begin
      fvec_q <= cmp_vec;
      fval_q <= 1'b1;
    end
  end

  assign fail_vec   = fvec_q;
  assign fail_valid = fval_q;
`else
  assign fail_vec   = '0;
  assign fail_valid = 1'b0;
`endif

endmodule

// File: tb/tb_maj_bist_ctrl.sv
// Directed bench: N=5/THRESH=3 controllers at LAT=0, LAT=1 and LAT=2 against behavioural DUTs.
module tb_maj_bist_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  int   mode = 0;

  int total = 0;
  int bad   = 0;

  // LAT=0 controller with a selectable combinational DUT
  logic [4:0]  x0, fv0;
  logic        y0, busy0, done0, pass0, fval0;
  logic [31:0] err0;
  // LAT=1 and LAT=2 controllers, each feeding a 2-stage registered golden DUT
  logic [4:0]  x1, fv1, x2, fv2;
  logic        y1, busy1, done1, pass1, fval1;
  logic        y2, busy2, done2, pass2, fval2;
  logic [31:0] err1, err2;
  logic        r1a, r1b, r2a, r2b;

  logic        exp_fval_inv, exp_fval_last;
  logic [4:0]  exp_fv_last;

  int d0_at, d0_cnt, d1_at, d2_at, d2_cnt;
  logic        c1_busy, c1_pass;
  logic [4:0]  c1_x;
  logic [31:0] c1_err;

  always #5 clk = ~clk;

  function automatic logic maj5(input logic [4:0] v);
    return ($countones(v) >= 3);
  endfunction

  assign y0 = (mode == 1) ? ~maj5(x0) : ((mode == 2) && (x0 == 5'h1f)) ? 1'b0 : maj5(x0);

  always @(posedge clk) begin
    r1a <= maj5(x1); r1b <= r1a;
    r2a <= maj5(x2); r2b <= r2a;
  end
  assign y1 = r1b;
  assign y2 = r2b;

  maj_bist_ctrl #(.N(5), .THRESH(3), .LAT(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .x_out(x0), .y_in(y0), .busy(busy0), .done(done0),
    .pass(pass0), .err_count(err0), .fail_vec(fv0), .fail_valid(fval0));

  maj_bist_ctrl #(.N(5), .THRESH(3), .LAT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .x_out(x1), .y_in(y1), .busy(busy1), .done(done1),
    .pass(pass1), .err_count(err1), .fail_vec(fv1), .fail_valid(fval1));

  maj_bist_ctrl #(.N(5), .THRESH(3), .LAT(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .x_out(x2), .y_in(y2), .busy(busy2), .done(done2),
    .pass(pass2), .err_count(err2), .fail_vec(fv2), .fail_valid(fval2));

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Pulse start; cycle 1 is the cycle after the sampling edge. Optionally inject start / rst mid-sweep.
  task automatic sweep(input int start_at, input int rst_at);
    d0_at = 0; d0_cnt = 0; d1_at = 0; d2_at = 0; d2_cnt = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    c1_busy = busy0; c1_pass = pass0; c1_x = x0; c1_err = err0;
    for (int c = 1; c <= 45; c++) begin
      if (done0) begin d0_cnt++; if (d0_at == 0) d0_at = c; end
      if (done1 && d1_at == 0) d1_at = c;
      if (done2) begin d2_cnt++; if (d2_at == 0) d2_at = c; end
      if (c == start_at) start = 1'b1;
      if (c == rst_at) rst = 1'b1;
      tick();
      start = 1'b0;
      if (c == rst_at) begin rst = 1'b0; return; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1;
    tick(); tick();
    total++; if (x0 !== 5'd0)  begin bad++; $display("FAIL reset_x got=%0d want=0", x0); end
    total++; if (busy0 !== 1'b0 || done0 !== 1'b0 || pass0 !== 1'b0) begin
      bad++; $display("FAIL reset_flags got busy=%b done=%b pass=%b want 000", busy0, done0, pass0); end
    total++; if (err0 !== 32'd0) begin bad++; $display("FAIL reset_err got=%0d want=0", err0); end
    total++; if (fv0 !== 5'd0 || fval0 !== 1'b0) begin
      bad++; $display("FAIL reset_fail got vec=%0d valid=%b want 0/0", fv0, fval0); end
    rst = 1'b0; start = 1'b0;
    tick(); tick();
    total++; if (busy0 !== 1'b0 || busy2 !== 1'b0) begin
      bad++; $display("FAIL reset_idle_busy got=%b/%b want=0/0", busy0, busy2); end
  endtask

  task automatic test_golden();
    mode = 0;
    sweep(0, 0);
    total++; if (c1_busy !== 1'b1 || c1_x !== 5'd0) begin
      bad++; $display("FAIL golden_first_cycle got busy=%b x=%0d want busy=1 x=0", c1_busy, c1_x); end
    total++; if (d0_at != 33) begin bad++; $display("FAIL golden_done_at got=%0d want=33", d0_at); end
    total++; if (d0_cnt != 1) begin bad++; $display("FAIL golden_done_pulses got=%0d want=1", d0_cnt); end
    total++; if (err0 !== 32'd0 || pass0 !== 1'b1) begin
      bad++; $display("FAIL golden_result got err=%0d pass=%b want err=0 pass=1", err0, pass0); end
    total++; if (fval0 !== 1'b0) begin bad++; $display("FAIL golden_fail_valid got=%b want=0", fval0); end
    total++; if (x0 !== 5'h1f || busy0 !== 1'b0) begin
      bad++; $display("FAIL golden_end got x=%0d busy=%b want x=31 busy=0", x0, busy0); end
    total++; if (d2_at != 35) begin bad++; $display("FAIL lat2_done_at got=%0d want=35", d2_at); end
    total++; if (d2_cnt != 1) begin bad++; $display("FAIL lat2_done_pulses got=%0d want=1", d2_cnt); end
    total++; if (err2 !== 32'd0 || pass2 !== 1'b1) begin
      bad++; $display("FAIL lat2_result got err=%0d pass=%b want err=0 pass=1", err2, pass2); end
    total++; if (d1_at != 34) begin bad++; $display("FAIL lat1_done_at got=%0d want=34", d1_at); end
    total++; if (err1 === 32'd0 || pass1 !== 1'b0) begin
      bad++; $display("FAIL lat1_mismatch got err=%0d pass=%b want err>0 pass=0", err1, pass1); end
  endtask

  task automatic test_inverted();
    mode = 1;
    sweep(0, 0);
    total++; if (c1_pass !== 1'b0) begin bad++; $display("FAIL inv_pass_cleared got=%b want=0", c1_pass); end
    total++; if (err0 !== 32'd32) begin bad++; $display("FAIL inv_err got=%0d want=32", err0); end
    total++; if (pass0 !== 1'b0) begin bad++; $display("FAIL inv_pass got=%b want=0", pass0); end
    total++; if (fv0 !== 5'd0 || fval0 !== exp_fval_inv) begin
      bad++; $display("FAIL inv_capture got vec=%0d valid=%b want vec=0 valid=%b", fv0, fval0, exp_fval_inv); end
  endtask

  task automatic test_last_vector();
    mode = 2;
    sweep(0, 0);
    total++; if (c1_err !== 32'd0) begin bad++; $display("FAIL last_err_cleared got=%0d want=0", c1_err); end
    total++; if (d0_at != 33) begin bad++; $display("FAIL last_done_at got=%0d want=33", d0_at); end
    total++; if (err0 !== 32'd1 || pass0 !== 1'b0) begin
      bad++; $display("FAIL last_result got err=%0d pass=%b want err=1 pass=0", err0, pass0); end
    total++; if (fv0 !== exp_fv_last || fval0 !== exp_fval_last) begin
      bad++; $display("FAIL last_capture got vec=%0d valid=%b want vec=%0d valid=%b",
                      fv0, fval0, exp_fv_last, exp_fval_last); end
  endtask

  task automatic test_start_ignored();
    mode = 0;
    sweep(10, 0);
    total++; if (d0_cnt != 1) begin bad++; $display("FAIL busy_start_pulses got=%0d want=1", d0_cnt); end
    total++; if (d0_at != 33) begin bad++; $display("FAIL busy_start_done_at got=%0d want=33", d0_at); end
    total++; if (err0 !== 32'd0 || pass0 !== 1'b1) begin
      bad++; $display("FAIL busy_start_result got err=%0d pass=%b want err=0 pass=1", err0, pass0); end
  endtask

  task automatic test_reset_mid();
    int seen;
    mode = 1;
    sweep(0, 12);
    total++; if (x0 !== 5'd0 || busy0 !== 1'b0 || done0 !== 1'b0 || pass0 !== 1'b0) begin
      bad++; $display("FAIL midrst_outputs got x=%0d busy=%b done=%b pass=%b want 0", x0, busy0, done0, pass0); end
    total++; if (err0 !== 32'd0 || fv0 !== 5'd0 || fval0 !== 1'b0) begin
      bad++; $display("FAIL midrst_err got err=%0d vec=%0d valid=%b want 0", err0, fv0, fval0); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy0 || done0 || busy2 || done2) seen++;
      tick();
    end
    total++; if (seen != 0) begin bad++; $display("FAIL midrst_stays_idle got active_cycles=%0d want=0", seen); end
  endtask

  task automatic test_start_with_rst();
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    tick();
    total++; if (busy0 !== 1'b0 || x0 !== 5'd0) begin
      bad++; $display("FAIL start_rst_same got busy=%b x=%0d want busy=0 x=0", busy0, x0); end
  endtask

  task automatic test_restart();
    mode = 0;
    sweep(0, 0);
    total++; if (d0_at != 33 || d0_cnt != 1) begin
      bad++; $display("FAIL restart_done got at=%0d pulses=%0d want at=33 pulses=1", d0_at, d0_cnt); end
    total++; if (err0 !== 32'd0 || pass0 !== 1'b1 || x0 !== 5'h1f) begin
      bad++; $display("FAIL restart_result got err=%0d pass=%b x=%0d want 0/1/31", err0, pass0, x0); end
    total++; if (d2_at != 35 || err2 !== 32'd0) begin
      bad++; $display("FAIL restart_lat2 got at=%0d err=%0d want at=35 err=0", d2_at, err2); end
  endtask

  initial begin
`ifdef MAJ_BIST_FAILCAP_EN
    exp_fval_inv = 1'b1; exp_fval_last = 1'b1; exp_fv_last = 5'h1f;
`else
    exp_fval_inv = 1'b0; exp_fval_last = 1'b0; exp_fv_last = 5'h00;
`endif
    test_reset();
    test_golden();
    test_inverted();
    test_last_vector();
    test_start_ignored();
    test_reset_mid();
    test_start_with_rst();
    test_restart();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
